// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and byte type.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_ACCEPT,
    WAIT_DONE
  } arb_state_t;

  typedef logic [7:0] uart_byte_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int range_n);
    return (range_n > 2) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Cyclic first-valid search: grants the first requester at or after i_ptr.
// Latency: purely combinational.
// Backpressure: i_en low forces an all-zero grant.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  localparam logic [IW:0] NN = (IW+1)'(N);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_c;
  logic          w_found;

  // Walk the requesters starting at the pointer, wrapping past N-1, take the first hit.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_c     = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_sum >= NN) w_sum = w_sum - NN;
      w_c = w_sum[IW-1:0];
      if (i_en && !w_found && i_req[w_c]) begin
        w_found  = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx    = w_c;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_CLIENTS byte producers; UART_TX_ARB_PRIO_EN gives client 0 strict priority.
// Latency: transfer at edge t -> load strobe in cycle t+1; retries every RETRY_CYCLES+1 cycles.
// Backpressure: req_ready only in IDLE; one byte in flight until the frame completes or the byte is dropped.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int RETRY_CYCLES = 7,
  parameter int MAX_RETRIES  = 255,
  localparam int IW = $clog2(NUM_CLIENTS)
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [NUM_CLIENTS-1:0]   req_valid,
  input  logic [NUM_CLIENTS*8-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]   req_ready,
  output logic                     tx_data_loaded,
  output uart_byte_t               tx_data_in,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [IW-1:0]            grant_id,
  output logic                     arb_busy,
  output logic                     sent,
  output logic                     err_drop
);

  localparam int WW = cnt_width(RETRY_CYCLES);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(RETRY_CYCLES - 1);
  localparam logic [7:0]    RETRY_LAST = 8'(MAX_RETRIES - 1);

  arb_state_t           r_state, w_next;
  logic [IW-1:0]        r_rr_ptr;
  logic [WW-1:0]        r_wait_cnt, w_wait_nxt;
  logic [7:0]           r_retry_cnt, w_retry_nxt;
  uart_byte_t           r_tx_data_in;
  logic [IW-1:0]        r_grant_id;
  logic                 r_tx_data_loaded, r_arb_busy, r_sent, r_err_drop;
  logic                 w_sent_nxt, w_drop_nxt;

  logic                   w_idle;
  logic [NUM_CLIENTS-1:0] w_rr_req, w_rr_gnt, w_gnt;
  logic [IW-1:0]          w_rr_idx, w_gnt_idx;
  logic                   w_rr_en, w_upd_ptr, w_xfer;

  assign w_idle = (r_state == IDLE);

`ifdef UART_TX_ARB_PRIO_EN
  // Client 0 bypasses the rotation; the search only ever sees clients 1..N-1.
  assign w_rr_req  = req_valid & ~NUM_CLIENTS'(1);
  assign w_rr_en   = w_idle && !req_valid[0];
  assign w_gnt     = (w_idle && req_valid[0]) ? NUM_CLIENTS'(1) : w_rr_gnt;
  assign w_gnt_idx = (w_idle && req_valid[0]) ? '0 : w_rr_idx;
  assign w_upd_ptr = (w_gnt_idx != '0);
`else
  assign w_rr_req  = req_valid;
  assign w_rr_en   = w_idle;
  assign w_gnt     = w_rr_gnt;
  assign w_gnt_idx = w_rr_idx;
  assign w_upd_ptr = 1'b1;
`endif

  rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
    .i_req (w_rr_req),
    .i_ptr (r_rr_ptr),
    .i_en  (w_rr_en),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = |(req_valid & w_gnt);

  // Next-state and pulse decode; acceptance (tx_busy) is checked before the retry timeout.
  always_comb begin
    w_next      = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_retry_nxt = r_retry_cnt;
    w_sent_nxt  = 1'b0;
    w_drop_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_next      = LOAD;
          w_retry_nxt = '0;
        end
      end
      LOAD: begin
        w_wait_nxt = '0;
        w_next     = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (tx_busy) begin
          w_next = WAIT_DONE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          if (r_retry_cnt == RETRY_LAST) begin
            w_drop_nxt = 1'b1;
            w_next     = IDLE;
          end else begin
            w_retry_nxt = r_retry_cnt + 1'b1;
            w_next      = LOAD;
          end
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        // busy low without done is treated as a glitch and ignored
        if (!tx_busy && tx_done) begin
          w_sent_nxt = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, counters and registered status outputs derived from the next state.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state          <= IDLE;
      r_wait_cnt       <= '0;
      r_retry_cnt      <= '0;
      r_tx_data_loaded <= 1'b0;
      r_arb_busy       <= 1'b0;
      r_sent           <= 1'b0;
      r_err_drop       <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_wait_cnt       <= w_wait_nxt;
      r_retry_cnt      <= w_retry_nxt;
      r_tx_data_loaded <= (w_next == LOAD);
      r_arb_busy       <= (w_next != IDLE);
      r_sent           <= w_sent_nxt;
      r_err_drop       <= w_drop_nxt;
    end
  end

  // Capture the granted byte and owner, and advance the rotation pointer past the winner.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_tx_data_in <= '0;
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
    end else if (w_idle && w_xfer) begin
      r_tx_data_in <= req_data[{w_gnt_idx, 3'b000} +: 8];
      r_grant_id   <= w_gnt_idx;
      if (w_upd_ptr)
        r_rr_ptr <= (w_gnt_idx == IW'(NUM_CLIENTS - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign tx_data_loaded = r_tx_data_loaded;
  assign tx_data_in     = r_tx_data_in;
  assign grant_id       = r_grant_id;
  assign arb_busy       = r_arb_busy;
  assign sent           = r_sent;
  assign err_drop       = r_err_drop;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: checks strobe at t+1, retry spacing RETRY_CYCLES+1, sent/err_drop on return to IDLE.
// Backpressure: the transmitter model ignores a chosen number of strobes and holds busy for a random frame.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int R = 7;
  localparam int M = 3;

  logic           clk = 1'b0;
  logic           areset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_data_loaded;
  logic [7:0]     tx_data_in;
  logic           tx_busy;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           arb_busy;
  logic           sent;
  logic           err_drop;

  uart_tx_arbiter #(.NUM_CLIENTS(N), .RETRY_CYCLES(R), .MAX_RETRIES(M)) dut (
    .clk            (clk),
    .areset         (areset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .tx_data_loaded (tx_data_loaded),
    .tx_data_in     (tx_data_in),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .grant_id       (grant_id),
    .arb_busy       (arb_busy),
    .sent           (sent),
    .err_drop       (err_drop)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         pend[N];
  logic [7:0] pdat[N];
  int         ptr = 0;
  bit         rereq_all = 0;
  int         last_gid;
  logic [31:0] last_rdy;
  logic [7:0] last_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_data[8*i +: 8] = pdat[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Winner = first pending client at or after ptr, cyclically (client 0 first when prioritized).
  function automatic int pick();
`ifdef UART_TX_ARB_PRIO_EN
    if (pend[0]) return 0;
    for (int i = 0; i < N; i++) begin
      int c = (ptr + i) % N;
      if (c != 0 && pend[c]) return c;
    end
`else
    for (int i = 0; i < N; i++) begin
      int c = (ptr + i) % N;
      if (pend[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One grant from IDLE through completion or drop; k = number of strobes the transmitter ignores.
  task automatic do_txn(input int k, input bit rst_mid);
    int         w;
    int         f;
    logic [7:0] b;
    if (!any_pend()) begin
      int c = $urandom_range(N-1);
      pend[c] = 1'b1;
      pdat[c] = 8'($urandom);
    end
    drive_reqs();
    #1;
    w = pick();
    chk("idle_busy", 32'(arb_busy), 32'd0);
    chk("req_ready", 32'(req_ready), 32'(1) << w);
    last_rdy = 32'(req_ready);
    b = pdat[w];
    step();
    last_gid  = int'(grant_id);
    last_byte = tx_data_in;
    pend[w] = 1'b0;
    if (rereq_all || $urandom_range(1) == 1) begin
      pend[w] = 1'b1;
      pdat[w] = 8'($urandom);
    end
`ifdef UART_TX_ARB_PRIO_EN
    if (w != 0) ptr = (w + 1) % N;
`else
    ptr = (w + 1) % N;
`endif
    drive_reqs();
    chk("load_sent", 32'(sent), 32'd0);
    chk("load_drop", 32'(err_drop), 32'd0);
    for (int a = 0; a < M; a++) begin
      chk("strobe", 32'(tx_data_loaded), 32'd1);
      chk("data", 32'(tx_data_in), 32'(b));
      chk("grant_id", 32'(grant_id), 32'(w));
      chk("ready_off", 32'(req_ready), 32'd0);
      if (a == k) break;
      if (a == M - 1) begin
        repeat (R) begin
          step();
          chk("gap_strobe", 32'(tx_data_loaded), 32'd0);
          chk("drop_early", 32'(err_drop), 32'd0);
        end
        step();
        chk("err_drop", 32'(err_drop), 32'd1);
        chk("drop_idle", 32'(arb_busy), 32'd0);
        return;
      end
      repeat (R) begin
        step();
        chk("gap_strobe", 32'(tx_data_loaded), 32'd0);
        chk("gap_busy", 32'(arb_busy), 32'd1);
      end
      step();
    end
    tx_busy = 1'b1;
    tx_done = 1'b0;
    f = $urandom_range(2, 6);
    repeat (f) begin
      step();
      chk("frame_strobe", 32'(tx_data_loaded), 32'd0);
      chk("frame_busy", 32'(arb_busy), 32'd1);
      chk("frame_sent", 32'(sent), 32'd0);
    end
    if (rst_mid) begin
      areset = 1'b1;
      #1;
      chk("rst_loaded", 32'(tx_data_loaded), 32'd0);
      chk("rst_data", 32'(tx_data_in), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(arb_busy), 32'd0);
      chk("rst_sent", 32'(sent), 32'd0);
      chk("rst_drop", 32'(err_drop), 32'd0);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      ptr = 0;
      for (int i = 0; i < N; i++) pend[i] = 1'b1;
      drive_reqs();
      #1;
      chk("rst_ready", 32'(req_ready), 32'(1) << pick());
      step();
      areset = 1'b0;
      return;
    end
    if ($urandom_range(1) == 1) begin
      tx_busy = 1'b0;
      tx_done = 1'b0;
      step();
      chk("glitch_hold", 32'(arb_busy), 32'd1);
      chk("glitch_sent", 32'(sent), 32'd0);
    end
    tx_busy = 1'b0;
    tx_done = 1'b1;
    step();
    chk("sent", 32'(sent), 32'd1);
    chk("done_idle", 32'(arb_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    areset  = 1'b1;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pdat[i] = 8'h00;
    end
    drive_reqs();
    @(negedge clk);
    @(negedge clk);
    chk("reset_loaded", 32'(tx_data_loaded), 32'd0);
    chk("reset_data", 32'(tx_data_in), 32'd0);
    chk("reset_gid", 32'(grant_id), 32'd0);
    chk("reset_busy", 32'(arb_busy), 32'd0);
    chk("reset_sent", 32'(sent), 32'd0);
    chk("reset_drop", 32'(err_drop), 32'd0);
    chk("reset_ready_none", 32'(req_ready), 32'd0);
    pend[1] = 1'b1; pend[2] = 1'b1;
    drive_reqs();
    #1;
    chk("reset_ready_comb", 32'(req_ready), 32'(1) << pick());
    step();
    areset = 1'b0;

    // all clients requesting continuously
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      pdat[i] = 8'($urandom);
    end
    rereq_all = 1'b1;
    for (int t = 0; t < 5; t++) begin
      do_txn(0, 1'b0);
`ifdef UART_TX_ARB_PRIO_EN
      chk("prio_order", 32'(last_gid), 32'd0);
`else
      chk("rr_order", 32'(last_gid), 32'(t % N));
`endif
    end
    rereq_all = 1'b0;

    // single byte from client 2
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    pend[2] = 1'b1;
    pdat[2] = 8'hA5;
    do_txn(0, 1'b0);
    chk("single_ready", last_rdy, 32'h4);
    chk("single_data", 32'(last_byte), 32'hA5);

    // two ignored strobes, accepted on the third
    do_txn(2, 1'b0);
    // never accepted: dropped after M strobes
    do_txn(M, 1'b0);

`ifdef UART_TX_ARB_PRIO_EN
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    pend[0] = 1'b1;
    pend[3] = 1'b1;
    rereq_all = 1'b1;
    for (int t = 0; t < 4; t++) begin
      do_txn(0, 1'b0);
      chk("prio_client0", 32'(last_gid), 32'd0);
    end
    rereq_all = 1'b0;
`endif

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_reqs();
        #1;
        chk("no_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("no_req_idle", 32'(arb_busy), 32'd0);
      end
      do_txn((($urandom_range(4) == 0) ? M : $urandom_range(M-1)), 1'b0);
    end

    // reset while a frame is in progress, then client 0 wins
    do_txn(0, 1'b1);
    do_txn(0, 1'b0);
    chk("post_reset_gid", 32'(last_gid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_CLIENTS` byte producers. It sits between the clients' valid/ready byte interfaces and the transmitter's `data_loaded`/`data_in`/`tx_busy`/`tx_done` interface. It latches one byte per grant and pulses the load strobe until the transmitter accepts it, retrying on miss. It then holds off further grants until the frame completes.

## Interface
- `NUM_CLIENTS`, 4: number of requesters, 2..8.
- `RETRY_CYCLES`, 7: cycles between load-strobe attempts; must be coprime with the transmitter baud divider.
- `MAX_RETRIES`, 255: attempts before the byte is dropped, 1..255.
- `clk` in 1: clock.
- `areset` in 1: reset, asynchronous, active-high.
- `req_valid` in NUM_CLIENTS: per-client byte pending.
- `req_data` in NUM_CLIENTS*8: client i byte at [8i+7:8i].
- `req_ready` out NUM_CLIENTS: one-hot grant; a byte transfers when valid&&ready.
- `tx_data_loaded` out 1: load strobe to the transmitter.
- `tx_data_in` out 8: byte to the transmitter; held stable from capture until return to IDLE.
- `tx_busy` in 1: transmitter frame in progress.
- `tx_done` in 1: transmitter last-frame-complete flag.
- `grant_id` out $clog2(NUM_CLIENTS): client owning the current byte.
- `arb_busy` out 1: not in IDLE.
- `sent` out 1: one-cycle pulse when a frame completes.
- `err_drop` out 1: one-cycle pulse when a byte is dropped after MAX_RETRIES.

## Operation
- States: IDLE, LOAD, WAIT_ACCEPT, WAIT_DONE.
- **IDLE:**
  - `req_ready` is combinational: one-hot for the first valid client at or after `rr_ptr`, searching cyclically; zero if none are valid.
  - On transfer: capture the byte into `tx_data_in` and the index into `grant_id`. Set `rr_ptr` to grant+1, wrapping NUM_CLIENTS-1 to 0. Clear `retry_cnt`. Go to LOAD.
- **LOAD:**
  - `tx_data_loaded`=1 for exactly this one cycle.
  - Clear `wait_cnt`. Go to WAIT_ACCEPT.
- **WAIT_ACCEPT:**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Else, if `wait_cnt`==RETRY_CYCLES-1:
    - If `retry_cnt`==MAX_RETRIES-1: pulse `err_drop` and go to IDLE.
    - Otherwise: increment `retry_cnt` and go to LOAD.
  - Otherwise increment `wait_cnt`.
- **WAIT_DONE:**
  - When `tx_busy`=0 and `tx_done`=1, pulse `sent` and go to IDLE.
  - `tx_busy`=0 with `tx_done`=0 (a glitch) stays in WAIT_DONE.
- `req_ready` is all-zero outside IDLE. Clients must hold `req_valid`/`req_data` until their transfer.
- Counters: `wait_cnt` is $clog2(RETRY_CYCLES) bits and `retry_cnt` is 8 bits; neither wraps, both bounded by the compares above.
- Simultaneous `tx_busy`=1 and timeout in WAIT_ACCEPT: acceptance wins, with no retry and no drop.
- Reset mid-operation: all state returns to IDLE immediately and the captured byte is discarded. A transmitter frame already in progress is not aborted; the first grant after reset waits in WAIT_ACCEPT/retry until the transmitter is free again.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - `tx_data_loaded`=0, `tx_data_in`=8'h00, `grant_id`=0.
  - `arb_busy`=0, `sent`=0, `err_drop`=0.
  - `req_ready` follows combinationally from `req_valid`.
- Transfer at edge t → `tx_data_loaded` high during cycle t+1.
- Each retry strobe follows the previous one by RETRY_CYCLES+1 cycles.
- The minimum gap between consecutive grants is one IDLE cycle after the `sent` pulse.
- All outputs except `req_ready` are registered.

## Configuration
- `UART_TX_ARB_PRIO_EN` defined:
  - Client 0 has strict priority: granted whenever valid in IDLE.
  - The round-robin search covers clients 1..NUM_CLIENTS-1 only.
  - `rr_ptr` is not updated on client-0 grants.
- Not defined: plain round-robin over all clients.

## Structure
- Package `uart_pkg`:
  - `arb_state_t` enum (IDLE, LOAD, WAIT_ACCEPT, WAIT_DONE).
  - The byte type `uart_byte_t` (logic [7:0]).
- Sub-module `rr_arbiter`:
  - Inputs: request vector, pointer, and an enable.
  - Outputs: one-hot grant and its binary index.
  - Reused for the priority and non-priority paths.

## Test plan
- **Single grant.** Client 2 valid with 8'hA5, transmitter model accepting on the first strobe → `req_ready`=4'b0100 for one cycle, `tx_data_in`=8'hA5, one `tx_data_loaded` pulse, and `sent` after `tx_busy` falls with `tx_done`=1.
- **Round-robin fairness.** All four clients valid continuously → grant order 0,1,2,3,0 with one byte per grant.
- **Retry.** Model ignores the first two strobes → exactly three strobes spaced RETRY_CYCLES+1=8 cycles apart, then WAIT_DONE.
- **Drop.** With MAX_RETRIES=3, `tx_busy` never rises → three strobes, one `err_drop` pulse, and the next client is granted.
- **Reset mid-frame.** `areset` asserted in WAIT_DONE → all outputs at reset values the same cycle; after release, client 0 is granted first.
- **Priority.** With `UART_TX_ARB_PRIO_EN` defined, clients 0 and 3 valid continuously → client 0 is granted on every grant and client 3 is never granted.
